// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - strobe inputs and score/combo status outputs of score_keeper
interface score_keeper_if #(
    parameter int DIGITS  = 4,
    parameter int COMBO_W = 7
);
    logic                  hit_pulse;
    logic                  miss_pulse;
    logic                  clear;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [COMBO_W-1:0]    combo;
    logic [2:0]            multiplier;
    logic                  busy;
    logic                  dropped;

    modport master (
        output hit_pulse,
        output miss_pulse,
        output clear,
        input  score_bcd,
        input  combo,
        input  multiplier,
        input  busy,
        input  dropped
    );

    modport slave (
        input  hit_pulse,
        input  miss_pulse,
        input  clear,
        output score_bcd,
        output combo,
        output multiplier,
        output busy,
        output dropped
    );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - combo/multiplier tracking and one-point-per-clock BCD score drain
module score_keeper #(
    parameter int DIGITS   = 4,
    parameter int COMBO_W  = 7,
    parameter int STEP     = 10,
    parameter int MAX_MULT = 4,
    parameter int PEND_W   = 5
) (
    input  logic          clk,
    input  logic          reset,
    score_keeper_if.slave sk
);
    typedef enum logic {IDLE, ADD} state_t;

    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [PEND_W:0]    PEND_MAX  = {1'b0, {PEND_W{1'b1}}};

    state_t                state_q, state_next;
    logic [COMBO_W-1:0]    combo_q, combo_next;
    logic [2:0]            mult_q, mult_next;
    logic [PEND_W-1:0]     pend_q, pend_next;
    logic [4*DIGITS-1:0]   score_q, score_next;
    logic                  dropped_q, dropped_next;
    logic                  busy_q;

    logic                  is_hit;
    logic                  drain;
    logic [2:0]            points;
    logic [PEND_W:0]       pend_wide;

    function automatic logic [2:0] mult_of(input logic [COMBO_W-1:0] c);
        int tier;
        tier = int'(c) / STEP;
        if (tier > MAX_MULT - 1)
            tier = MAX_MULT - 1;
        return 3'(tier + 1);
    endfunction

    // An all-9s score leaves the carry set after the last digit; hold instead of wrapping.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] s);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        r     = s;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (s[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = s[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return carry ? s : r;
    endfunction

    assign is_hit = sk.hit_pulse & ~sk.miss_pulse;
    assign drain  = (state_q == ADD);
    assign points = is_hit ? mult_q : 3'd0;

    always_comb begin
        combo_next   = combo_q;
        mult_next    = mult_q;
        score_next   = score_q;
        dropped_next = dropped_q;
        pend_next    = pend_q;
        state_next   = state_q;

        if (drain)
            score_next = bcd_inc(score_q);

        if (sk.miss_pulse) begin
            combo_next = '0;
            mult_next  = 3'd1;
        end else if (sk.hit_pulse) begin
            combo_next = (combo_q == COMBO_MAX) ? combo_q : combo_q + 1'b1;
            mult_next  = mult_of(combo_next);
        end

        // Points use the pre-update multiplier; drain only happens with pending nonzero.
        pend_wide = {1'b0, pend_q} - {{PEND_W{1'b0}}, drain} + (PEND_W+1)'(points);
        if (pend_wide > PEND_MAX) begin
            pend_next    = '1;
            dropped_next = 1'b1;
        end else begin
            pend_next = pend_wide[PEND_W-1:0];
        end

        state_next = (pend_next != '0) ? ADD : IDLE;

        if (sk.clear) begin
            combo_next   = '0;
            mult_next    = 3'd1;
            score_next   = '0;
            dropped_next = 1'b0;
            pend_next    = '0;
            state_next   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            combo_q   <= '0;
            mult_q    <= 3'd1;
            pend_q    <= '0;
            score_q   <= '0;
            dropped_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_next;
            combo_q   <= combo_next;
            mult_q    <= mult_next;
            pend_q    <= pend_next;
            score_q   <= score_next;
            dropped_q <= dropped_next;
            busy_q    <= (pend_next != '0);
        end
    end

    assign sk.score_bcd  = score_q;
    assign sk.combo      = combo_q;
    assign sk.multiplier = mult_q;
    assign sk.busy       = busy_q;
    assign sk.dropped    = dropped_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed table and sequence checks for score_keeper
module tb_score_keeper;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    score_keeper_if #(.DIGITS(4), .COMBO_W(7)) sk ();

    score_keeper #(
        .DIGITS(4), .COMBO_W(7), .STEP(10), .MAX_MULT(4), .PEND_W(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sk    (sk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        hit;
        logic        miss;
        logic        clr;
        logic [6:0]  combo;
        logic [2:0]  mult;
        logic [15:0] score;
        logic        busy;
        logic        dropped;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic m, input logic c);
        sk.hit_pulse  = h;
        sk.miss_pulse = m;
        sk.clear      = c;
    endtask

    task automatic do_clear();
        drive(0, 0, 1);
        tick();
        drive(0, 0, 0);
    endtask

    task automatic hits_spaced(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0);
            tick();
            drive(0, 0, 0);
            repeat (gap - 1) tick();
        end
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int k;
        k = 0;
        while (sk.busy && k < max_cycles) begin
            tick();
            k++;
        end
        chk(name, {31'd0, sk.busy}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(0, 0, 0);

        //           hit miss clr combo mult score    busy drop
        vt[0]  = '{0, 0, 0, 7'd0, 3'd1, 16'h0000, 0, 0};
        vt[1]  = '{1, 0, 0, 7'd1, 3'd1, 16'h0000, 1, 0};
        vt[2]  = '{0, 0, 0, 7'd1, 3'd1, 16'h0001, 0, 0};
        vt[3]  = '{1, 0, 0, 7'd2, 3'd1, 16'h0001, 1, 0};
        vt[4]  = '{0, 0, 0, 7'd2, 3'd1, 16'h0002, 0, 0};
        vt[5]  = '{1, 0, 0, 7'd3, 3'd1, 16'h0002, 1, 0};
        vt[6]  = '{0, 0, 0, 7'd3, 3'd1, 16'h0003, 0, 0};
        vt[7]  = '{1, 1, 0, 7'd0, 3'd1, 16'h0003, 0, 0};
        vt[8]  = '{1, 0, 1, 7'd0, 3'd1, 16'h0000, 0, 0};
        vt[9]  = '{1, 0, 0, 7'd1, 3'd1, 16'h0000, 1, 0};
        vt[10] = '{0, 1, 0, 7'd0, 3'd1, 16'h0001, 0, 0};
        vt[11] = '{1, 0, 0, 7'd1, 3'd1, 16'h0001, 1, 0};
        vt[12] = '{1, 0, 0, 7'd2, 3'd1, 16'h0002, 1, 0};
        vt[13] = '{0, 0, 0, 7'd2, 3'd1, 16'h0003, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_score", {16'd0, sk.score_bcd}, 32'h0);
        chk("rst_combo", {25'd0, sk.combo}, 32'd0);
        chk("rst_mult", {29'd0, sk.multiplier}, 32'd1);
        chk("rst_busy", {31'd0, sk.busy}, 32'd0);
        chk("rst_dropped", {31'd0, sk.dropped}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].hit, vt[i].miss, vt[i].clr);
            tick();
            chk($sformatf("vec%0d_combo", i), {25'd0, sk.combo}, {25'd0, vt[i].combo});
            chk($sformatf("vec%0d_mult", i), {29'd0, sk.multiplier}, {29'd0, vt[i].mult});
            chk($sformatf("vec%0d_score", i), {16'd0, sk.score_bcd}, {16'd0, vt[i].score});
            chk($sformatf("vec%0d_busy", i), {31'd0, sk.busy}, {31'd0, vt[i].busy});
            chk($sformatf("vec%0d_dropped", i), {31'd0, sk.dropped}, {31'd0, vt[i].dropped});
        end
        drive(0, 0, 0);

        // 25 hits: multiplier steps after hits 10 and 20
        do_clear();
        for (int i = 1; i <= 25; i++) begin
            hits_spaced(1, 4);
            if (i == 10) chk("m25_mult_after10", {29'd0, sk.multiplier}, 32'd2);
            if (i == 20) chk("m25_mult_after20", {29'd0, sk.multiplier}, 32'd3);
        end
        wait_idle("m25_drain", 20);
        chk("m25_score", {16'd0, sk.score_bcd}, 32'h0045);
        chk("m25_combo", {25'd0, sk.combo}, 32'd25);
        chk("m25_mult", {29'd0, sk.multiplier}, 32'd3);

        // 15 hits, miss, 1 hit
        do_clear();
        hits_spaced(15, 4);
        drive(0, 1, 0);
        tick();
        drive(0, 0, 0);
        chk("miss_combo", {25'd0, sk.combo}, 32'd0);
        chk("miss_mult", {29'd0, sk.multiplier}, 32'd1);
        hits_spaced(1, 2);
        wait_idle("miss_drain", 20);
        chk("miss_score", {16'd0, sk.score_bcd}, 32'h0021);
        chk("miss_combo2", {25'd0, sk.combo}, 32'd1);

        // preload 9998 at multiplier 1, then saturate at 9999
        do_clear();
        for (int b = 0; b < 1999; b++) begin
            drive(1, 0, 0);
            repeat (5) tick();
            drive(0, 1, 0);
            tick();
        end
        drive(1, 0, 0);
        repeat (3) tick();
        drive(0, 0, 0);
        wait_idle("pre_drain", 20);
        chk("pre_score", {16'd0, sk.score_bcd}, 32'h9998);
        hits_spaced(3, 2);
        wait_idle("sat_drain", 20);
        chk("sat_score", {16'd0, sk.score_bcd}, 32'h9999);
        tick();
        chk("sat_hold", {16'd0, sk.score_bcd}, 32'h9999);

        // pending saturation with multiplier 4
        do_clear();
        hits_spaced(30, 4);
        wait_idle("ps_pre_drain", 20);
        chk("ps_mult", {29'd0, sk.multiplier}, 32'd4);
        chk("ps_pre_score", {16'd0, sk.score_bcd}, 32'h0060);
        drive(1, 0, 0);
        repeat (10) tick();
        chk("ps_nodrop_at31", {31'd0, sk.dropped}, 32'd0);
        tick();
        chk("ps_drop_at34", {31'd0, sk.dropped}, 32'd1);
        tick();
        drive(0, 0, 0);
        wait_idle("ps_drain", 100);
        chk("ps_score", {16'd0, sk.score_bcd}, 32'h0102);
        chk("ps_combo", {25'd0, sk.combo}, 32'd42);
        chk("ps_dropped_sticky", {31'd0, sk.dropped}, 32'd1);
        do_clear();
        chk("ps_clear_dropped", {31'd0, sk.dropped}, 32'd0);
        chk("ps_clear_score", {16'd0, sk.score_bcd}, 32'h0);

        // asynchronous reset mid-drain with pending=3
        hits_spaced(20, 4);
        wait_idle("ar_pre_drain", 20);
        chk("ar_mult3", {29'd0, sk.multiplier}, 32'd3);
        drive(1, 0, 0);
        tick();
        drive(0, 0, 0);
        chk("ar_busy", {31'd0, sk.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_score", {16'd0, sk.score_bcd}, 32'h0);
        chk("ar_combo", {25'd0, sk.combo}, 32'd0);
        chk("ar_mult", {29'd0, sk.multiplier}, 32'd1);
        chk("ar_busy0", {31'd0, sk.busy}, 32'd0);
        chk("ar_dropped", {31'd0, sk.dropped}, 32'd0);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("ar_no_resume", {16'd0, sk.score_bcd}, 32'h0);

        // hit and miss together after a scored hit
        hits_spaced(1, 2);
        chk("hm_pre_score", {16'd0, sk.score_bcd}, 32'h0001);
        drive(1, 1, 0);
        tick();
        drive(0, 0, 0);
        chk("hm_combo", {25'd0, sk.combo}, 32'd0);
        chk("hm_busy", {31'd0, sk.busy}, 32'd0);
        tick();
        chk("hm_score", {16'd0, sk.score_bcd}, 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
